// File: rtl/winograd_tile_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : winograd_tile_ctrl_if
//  Description : Tile fetch, datapath and output-tile bundle of the Winograd
//                F(2x2,3x3) tile sequencer. The master modport is the
//                sequencer side and the slave modport is the environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface winograd_tile_ctrl_if #(
    parameter int ADDR_W = 8
);
    // tile fetch
    logic              rd_req;
    logic [ADDR_W-1:0] rd_row;
    logic [ADDR_W-1:0] rd_col;
    logic              rd_valid;
    logic [127:0]      rd_data;
    // datapath
    logic [127:0]      wg_data;
    logic [71:0]       wg_filter;
    logic              wg_in_valid;
    logic [63:0]       wg_ofmap;
    // output tile
    logic              out_valid;
    logic              out_ready;
    logic [63:0]       out_data;
    logic [ADDR_W-1:0] out_row;
    logic [ADDR_W-1:0] out_col;

    modport master (
        output rd_req, rd_row, rd_col,
        input  rd_valid, rd_data,
        output wg_data, wg_filter, wg_in_valid,
        input  wg_ofmap,
        output out_valid, out_data, out_row, out_col,
        input  out_ready
    );

    modport slave (
        input  rd_req, rd_row, rd_col,
        output rd_valid, rd_data,
        input  wg_data, wg_filter, wg_in_valid,
        output wg_ofmap,
        input  out_valid, out_data, out_row, out_col,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/winograd_tile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : winograd_tile_ctrl
//  Description : Sequencer for the Winograd F(2x2,3x3) datapath. Walks the
//                input map in stride-2 raster order, fetches one 4x4 tile at
//                a time, issues it with the stored filter, waits the datapath
//                latency and hands the 2x2 result out on a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
module winograd_tile_ctrl #(
    parameter int IMG_W    = 8,
    parameter int IMG_H    = 8,
    parameter int PIPE_LAT = 3,
    parameter int ADDR_W   = 8
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    input  wire logic        start,
    input  wire logic        filter_ld,
    input  wire logic [71:0] filter_in,
    output logic             busy,
    output logic             done,
    winograd_tile_ctrl_if.master bus
);

    localparam int c_CNT_W = (PIPE_LAT < 1) ? 1 : $clog2(PIPE_LAT + 1);

    localparam logic [c_CNT_W-1:0] c_LAT      = c_CNT_W'(PIPE_LAT);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [ADDR_W-1:0]  c_LAST_ROW = ADDR_W'(IMG_H - 4);
    localparam logic [ADDR_W-1:0]  c_LAST_COL = ADDR_W'(IMG_W - 4);
    localparam logic [ADDR_W-1:0]  c_STEP     = ADDR_W'(2);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_ISSUE = 3'd2;
    localparam logic [2:0] c_WAIT  = 3'd3;
    localparam logic [2:0] c_OUT   = 3'd4;
    localparam logic [2:0] c_DONE  = 3'd5;

    logic [2:0]         r_state;
    logic [ADDR_W-1:0]  r_row;
    logic [ADDR_W-1:0]  r_col;
    logic [c_CNT_W-1:0] r_cnt;
    logic [71:0]        r_filter;
    logic [127:0]       r_tile;
    logic               r_rd_req;
    logic               r_wg_in_valid;
    logic               r_out_valid;
    logic [63:0]        r_out_data;
    logic [ADDR_W-1:0]  r_out_row;
    logic [ADDR_W-1:0]  r_out_col;
    logic               r_busy;
    logic               r_done;

    logic               w_last;

    // the current origin is the final tile of the frame
    assign w_last = (r_row == c_LAST_ROW) && (r_col == c_LAST_COL);

    assign bus.rd_req      = r_rd_req;
    assign bus.rd_row      = r_row;
    assign bus.rd_col      = r_col;
    assign bus.wg_data     = r_tile;
    assign bus.wg_filter   = r_filter;
    assign bus.wg_in_valid = r_wg_in_valid;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_data    = r_out_data;
    assign bus.out_row     = r_out_row;
    assign bus.out_col     = r_out_col;
    assign busy            = r_busy;
    assign done            = r_done;

    // tile sequencer: one tile in flight, every output registered
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= c_IDLE;
            r_row         <= '0;
            r_col         <= '0;
            r_cnt         <= '0;
            r_filter      <= '0;
            r_tile        <= '0;
            r_rd_req      <= 1'b0;
            r_wg_in_valid <= 1'b0;
            r_out_valid   <= 1'b0;
            r_out_data    <= '0;
            r_out_row     <= '0;
            r_out_col     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            // single-cycle strobes fall back unless a transition raises them
            r_wg_in_valid <= 1'b0;
            r_done        <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    // filter load and start may coincide; the new filter wins
                    if (filter_ld) begin
                        r_filter <= filter_in;
                    end
                    if (start) begin
                        r_row    <= '0;
                        r_col    <= '0;
                        r_rd_req <= 1'b1;
                        r_busy   <= 1'b1;
                        r_state  <= c_FETCH;
                    end
                end
                c_FETCH: begin
                    if (bus.rd_valid) begin
                        r_tile        <= bus.rd_data;
                        r_rd_req      <= 1'b0;
                        r_wg_in_valid <= 1'b1;
                        r_state       <= c_ISSUE;
                    end
                end
                c_ISSUE: begin
                    // the first WAIT cycle is one cycle after the issue cycle
                    r_cnt   <= c_CNT_ONE;
                    r_state <= c_WAIT;
                end
                c_WAIT: begin
                    if (r_cnt == c_LAT) begin
                        r_out_data  <= bus.wg_ofmap;
                        r_out_row   <= r_row;
                        r_out_col   <= r_col;
                        r_out_valid <= 1'b1;
                        r_state     <= c_OUT;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end
                c_OUT: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        if (w_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= c_DONE;
                        end else begin
                            if (r_col == c_LAST_COL) begin
                                r_col <= '0;
                                r_row <= r_row + c_STEP;
                            end else begin
                                r_col <= r_col + c_STEP;
                            end
                            r_rd_req <= 1'b1;
                            r_state  <= c_FETCH;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_winograd_tile_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_winograd_tile_ctrl
//  Description : Directed bench for winograd_tile_ctrl: an 8x8 instance driven
//                from a per-tile vector table, and a 4x4 instance for the
//                single-tile frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_winograd_tile_ctrl;

    localparam int PIPE_LAT = 3;

    typedef struct {
        logic [7:0]   row;
        logic [7:0]   col;
        int           rd_dly;
        int           rdy_dly;
        bit           poke;
        logic [127:0] data;
        logic [63:0]  ofmap;
    } tv_t;

    logic        clk;
    logic        rstn;
    logic        start8, filter_ld8, busy8, done8;
    logic [71:0] filter_in8;
    logic        start4, filter_ld4, busy4, done4;
    logic [71:0] filter_in4;

    int          checks;
    int          failures;
    int          done_cnt8;
    logic [71:0] exp_filter;
    tv_t         tv [9];

    winograd_tile_ctrl_if #(.ADDR_W(8)) if8 ();
    winograd_tile_ctrl_if #(.ADDR_W(8)) if4 ();

    winograd_tile_ctrl #(.IMG_W(8), .IMG_H(8), .PIPE_LAT(PIPE_LAT), .ADDR_W(8)) dut8 (
        .clk(clk), .rstn(rstn), .start(start8), .filter_ld(filter_ld8),
        .filter_in(filter_in8), .busy(busy8), .done(done8), .bus(if8.master)
    );

    winograd_tile_ctrl #(.IMG_W(4), .IMG_H(4), .PIPE_LAT(PIPE_LAT), .ADDR_W(8)) dut4 (
        .clk(clk), .rstn(rstn), .start(start4), .filter_ld(filter_ld4),
        .filter_in(filter_in4), .busy(busy4), .done(done4), .bus(if4.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // count done pulses of the 8x8 instance
    always @(negedge clk) begin
        if (done8 === 1'b1) done_cnt8++;
    end

    // absolute time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one full tile on the 8x8 instance: fetch, issue, wait, output
    task automatic do_tile(input tv_t v, input bit last);
        int n;
        n = 0;
        while (if8.rd_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk("rd_req_rise", if8.rd_req, 1);
        chk("rd_row", if8.rd_row, v.row);
        chk("rd_col", if8.rd_col, v.col);
        for (int k = 0; k < v.rd_dly; k++) begin
            tick();
            chk("rd_req_hold", if8.rd_req, 1);
            chk("rd_row_hold", if8.rd_row, v.row);
            chk("rd_col_hold", if8.rd_col, v.col);
        end
        if8.rd_valid = 1'b1;
        if8.rd_data  = v.data;
        tick();
        if8.rd_valid  = 1'b0;
        if8.rd_data   = ~v.data;
        if8.wg_ofmap  = ~v.ofmap;
        chk("wg_in_valid", if8.wg_in_valid, 1);
        chk("wg_data", if8.wg_data, v.data);
        chk("wg_filter", if8.wg_filter, exp_filter);
        chk("rd_req_drop", if8.rd_req, 0);
        for (int k = 1; k <= PIPE_LAT; k++) begin
            tick();
            if (k == 1) begin
                chk("wg_in_valid_pulse", if8.wg_in_valid, 0);
                if8.rd_valid = 1'b1;
                if (v.poke) begin
                    start8     = 1'b1;
                    filter_ld8 = 1'b1;
                    filter_in8 = ~exp_filter;
                end
            end
            if8.wg_ofmap = (k == PIPE_LAT) ? v.ofmap : ~v.ofmap;
        end
        tick();
        if8.wg_ofmap = ~v.ofmap;
        start8       = 1'b0;
        filter_ld8   = 1'b0;
        chk("out_valid", if8.out_valid, 1);
        chk("out_data", if8.out_data, v.ofmap);
        chk("out_row", if8.out_row, v.row);
        chk("out_col", if8.out_col, v.col);
        chk("wg_filter_frame", if8.wg_filter, exp_filter);
        for (int k = 0; k < v.rdy_dly; k++) begin
            tick();
            chk("out_valid_stall", if8.out_valid, 1);
            chk("out_data_stall", if8.out_data, v.ofmap);
            chk("out_rowcol_stall", {if8.out_row, if8.out_col}, {v.row, v.col});
            chk("rd_req_stall", if8.rd_req, 0);
            chk("wg_in_valid_stall", if8.wg_in_valid, 0);
        end
        if8.rd_valid  = 1'b0;
        if8.out_ready = 1'b1;
        tick();
        if8.out_ready = 1'b0;
        chk("out_valid_clear", if8.out_valid, 0);
        if (last) begin
            chk("done_pulse", done8, 1);
            chk("busy_at_done", busy8, 0);
        end else begin
            chk("rd_req_next", if8.rd_req, 1);
            chk("busy_mid", busy8, 1);
            chk("done_mid", done8, 0);
        end
    endtask

    task automatic run_frame();
        for (int i = 0; i < 9; i++) do_tile(tv[i], i == 8);
        tick();
        chk("done_one_cycle", done8, 0);
        chk("busy_after", busy8, 0);
    endtask

    initial begin
        checks = 0; failures = 0; done_cnt8 = 0;
        tv[0] = '{8'd0, 8'd0, 0, 0, 1'b0, {16{8'h11}}, 64'h0001_0002_0003_0004};
        tv[1] = '{8'd0, 8'd2, 3, 0, 1'b0, {16{8'h22}}, 64'h0011_0012_0013_0014};
        tv[2] = '{8'd0, 8'd4, 0, 5, 1'b0, {16{8'h33}}, 64'h0021_0022_0023_0024};
        tv[3] = '{8'd2, 8'd0, 1, 1, 1'b1, {16{8'h44}}, 64'h0031_0032_0033_0034};
        tv[4] = '{8'd2, 8'd2, 0, 2, 1'b0, {16{8'h55}}, 64'h0041_0042_0043_0044};
        tv[5] = '{8'd2, 8'd4, 2, 0, 1'b0, {16{8'h66}}, 64'h0051_0052_0053_0054};
        tv[6] = '{8'd4, 8'd0, 0, 0, 1'b0, {16{8'h77}}, 64'h0061_0062_0063_0064};
        tv[7] = '{8'd4, 8'd2, 0, 1, 1'b0, {16{8'h88}}, 64'h0071_0072_0073_0074};
        tv[8] = '{8'd4, 8'd4, 1, 0, 1'b0, {16{8'h99}}, 64'h0081_0082_0083_0084};

        rstn = 1'b0;
        start8 = 1'b0; filter_ld8 = 1'b0; filter_in8 = '0;
        start4 = 1'b0; filter_ld4 = 1'b0; filter_in4 = '0;
        if8.rd_valid = 1'b0; if8.rd_data = '0; if8.wg_ofmap = '0; if8.out_ready = 1'b0;
        if4.rd_valid = 1'b0; if4.rd_data = '0; if4.wg_ofmap = '0; if4.out_ready = 1'b0;
        tick();
        tick();
        chk("rst_busy", busy8, 0);
        chk("rst_done", done8, 0);
        chk("rst_rd_req", if8.rd_req, 0);
        chk("rst_wg_filter", if8.wg_filter, 0);
        chk("rst_out_valid", if8.out_valid, 0);
        chk("rst_rd_req4", if4.rd_req, 0);
        rstn = 1'b1;
        tick();

        // single-tile 4x4 frame
        filter_ld4 = 1'b1; filter_in4 = 72'h030303060606090909; start4 = 1'b1;
        tick();
        filter_ld4 = 1'b0; start4 = 1'b0; filter_in4 = '0;
        chk("f4_rd_req", if4.rd_req, 1);
        chk("f4_rd_rowcol", {if4.rd_row, if4.rd_col}, 16'h0000);
        chk("f4_busy", busy4, 1);
        if4.rd_valid = 1'b1;
        if4.rd_data  = 128'h01010101020202020303030304040404;
        tick();
        if4.rd_valid = 1'b0;
        if4.wg_ofmap = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("f4_wg_in_valid", if4.wg_in_valid, 1);
        chk("f4_wg_data", if4.wg_data, 128'h01010101020202020303030304040404);
        chk("f4_wg_filter", if4.wg_filter, 72'h030303060606090909);
        for (int k = 1; k <= PIPE_LAT; k++) begin
            tick();
            chk("f4_wg_in_valid_low", if4.wg_in_valid, 0);
            if4.wg_ofmap = (k == PIPE_LAT) ? 64'h0123_4567_89AB_CDEF : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        tick();
        if4.wg_ofmap = 64'hFFFF_FFFF_FFFF_FFFF;
        chk("f4_out_valid", if4.out_valid, 1);
        chk("f4_out_data", if4.out_data, 64'h0123_4567_89AB_CDEF);
        chk("f4_out_rowcol", {if4.out_row, if4.out_col}, 16'h0000);
        chk("f4_done_early", done4, 0);
        if4.out_ready = 1'b1;
        tick();
        if4.out_ready = 1'b0;
        chk("f4_out_valid_clear", if4.out_valid, 0);
        chk("f4_done", done4, 1);
        chk("f4_busy_done", busy4, 0);
        tick();
        chk("f4_done_once", done4, 0);

        // full 8x8 frame with stalls, pokes and spurious rd_valid
        exp_filter = 72'h0A0B0C_0D0E0F_101112;
        filter_ld8 = 1'b1; filter_in8 = exp_filter; start8 = 1'b1;
        tick();
        filter_ld8 = 1'b0; start8 = 1'b0; filter_in8 = '0;
        run_frame();
        chk("frame1_done_count", done_cnt8, 1);

        // second frame, reset during WAIT of tile 4
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int i = 0; i < 4; i++) do_tile(tv[i], 1'b0);
        chk("t4_rd_req", if8.rd_req, 1);
        if8.rd_valid = 1'b1; if8.rd_data = tv[4].data;
        tick();
        if8.rd_valid = 1'b0;
        tick();
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("mrst_rd_req", if8.rd_req, 0);
        chk("mrst_rd_rowcol", {if8.rd_row, if8.rd_col}, 16'h0000);
        chk("mrst_wg", {if8.wg_in_valid, if8.wg_data}, 0);
        chk("mrst_wg_filter", if8.wg_filter, 0);
        chk("mrst_out_valid", if8.out_valid, 0);
        chk("mrst_out_data", if8.out_data, 0);
        chk("mrst_out_rowcol", {if8.out_row, if8.out_col}, 16'h0000);
        chk("mrst_busy_done", {busy8, done8}, 0);
        tick();
        tick();
        chk("mrst_idle", {if8.rd_req, busy8}, 0);
        chk("mrst_no_done", done_cnt8, 1);

        // restart without reloading: filter stays cleared
        exp_filter = '0;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        chk("rs_rd_rowcol", {if8.rd_row, if8.rd_col}, 16'h0000);
        chk("rs_filter", if8.wg_filter, 0);
        run_frame();
        chk("frame3_done_count", done_cnt8, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/winograd_tile_ctrl.md
Name: winograd_tile_ctrl

Overview:
Sequencer for the Winograd F(2x2,3x3) datapath (winograd_top).
- Walks an IMG_H x IMG_W input feature map in raster order with stride 2.
- Fetches each 4x4 input tile (128 bits, 16 x 8-bit) through a request/valid port and presents it with a stored 3x3 filter (72 bits) to the datapath.
- Waits the datapath latency, then emits the 2x2 output tile (64 bits, 4 x 16-bit) on a valid/ready port tagged with its coordinates.
- Exactly one tile is in flight at a time.

Parameters:
- IMG_W, 8, input width in pixels; even, >= 4
- IMG_H, 8, input height in pixels; even, >= 4
- PIPE_LAT, 3, cycles from the wg_in_valid cycle to the cycle ofmap is valid; >= 1
- ADDR_W, 8, width of row/col coordinates

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  synchronous active-low reset
- start  in  1  begin a frame; sampled only in IDLE
- filter_ld  in  1  load filter_in into filter register; sampled only in IDLE
- filter_in  in  72  3x3 filter, 8-bit taps
- busy  out  1  high from FETCH through last output handshake
- done  out  1  one-cycle pulse after the last tile is accepted
- rd_req  out  1  tile fetch request
- rd_row  out  ADDR_W  tile origin row
- rd_col  out  ADDR_W  tile origin column
- rd_valid  in  1  rd_data valid; honoured only in FETCH
- rd_data  in  128  4x4 input tile
- wg_data  out  128  to datapath data
- wg_filter  out  72  to datapath filter
- wg_in_valid  out  1  tile presented this cycle
- wg_ofmap  in  64  datapath ofmap
- out_valid  out  1  output tile valid
- out_ready  in  1  consumer accepts
- out_data  out  64  captured 2x2 output tile
- out_row  out  ADDR_W  output tile origin row
- out_col  out  ADDR_W  output tile origin column

Behaviour:
- Reset (rstn low at a rising edge) clears all outputs to 0, the filter register to 0 and the tile counters to 0, and sets state to IDLE. This applies in any state, including mid-frame. No done pulse is produced on reset.
- Tile grid:
  - Origins: row r in {0, 2, ..., IMG_H-4}; col c in {0, 2, ..., IMG_W-4}.
  - Raster order: c increments fastest, then r.
  - Tile count = ((IMG_H-2)/2) * ((IMG_W-2)/2); 9 tiles for 8x8, 1 tile for 4x4.
- States: IDLE, FETCH, ISSUE, WAIT, OUT, DONE.
- IDLE:
  - filter_ld=1: latch filter_in into the filter register.
  - start=1: set r=c=0 and go to FETCH.
  - If both are asserted in the same cycle, the filter loads and FETCH begins with the new filter.
- FETCH:
  - rd_req=1; rd_row/rd_col hold the origin stable.
  - On rd_valid=1: latch rd_data into the tile register, drop rd_req, go to ISSUE.
  - rd_req rises the cycle after start was sampled.
- ISSUE: exactly one cycle; wg_in_valid=1. wg_data is the tile register; wg_filter is the filter register, driven continuously and stable for the whole frame.
- WAIT:
  - Count PIPE_LAT cycles after the ISSUE cycle.
  - At the end of the cycle ISSUE+PIPE_LAT, latch wg_ofmap into out_data and set out_row=r, out_col=c.
  - Go to OUT with out_valid=1.
- OUT:
  - out_valid, out_data, out_row and out_col stay stable until out_valid & out_ready.
  - On handshake, if not the last tile: advance (c += 2; if c > IMG_W-4 then c=0, r += 2), clear out_valid, go to FETCH.
  - On handshake of the last tile: clear out_valid, go to DONE.
- DONE: done=1 for one cycle, busy=0 in that cycle, then IDLE.
- Ignored inputs:
  - rd_valid outside FETCH.
  - start and filter_ld outside IDLE; the filter cannot change mid-frame.
  - wg_ofmap outside the capture cycle.
- Throughput per tile: FETCH (>= 1 cycle) + 1 + PIPE_LAT + OUT (>= 1 cycle).

Test Plan:
1. 4x4 frame: filter_ld with 72'h030303060606090909, then start; return rd_data=128'h01010101020202020303030304040404 one cycle after rd_req -> rd_row=rd_col=0; single wg_in_valid pulse with those data and filter; out_data equals wg_ofmap sampled PIPE_LAT cycles later; out_row=out_col=0; done pulses once, the cycle after the handshake.
2. 8x8 frame with out_ready tied 1 -> 9 outputs, origins (0,0),(0,2),(0,4),(2,0),...,(4,4) in order; done exactly once; busy low afterwards.
3. Backpressure: hold out_ready=0 for 5 cycles on tile 2 -> out_valid and out_data/out_row/out_col stable; no rd_req until the handshake.
4. Delayed fetch: rd_valid withheld 3 cycles -> rd_req, rd_row and rd_col held stable; spurious rd_valid pulses in WAIT/OUT have no effect.
5. Reset mid-frame: rstn=0 for one cycle during WAIT of tile 4 -> next cycle all outputs 0, state IDLE, no done; a new start restarts at (0,0) with filter 0 unless reloaded.
6. start and filter_ld pulsed while busy -> ignored; wg_filter unchanged and the frame completes normally with 9 tiles.
